riscv_ex_muldiv_unit: RTL
=========================

RISCV_EX_MULDIV_UNIT -- requirements
Module: riscv_ex_muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, operand and result width; legal values are 32 or 64.
REQ-002 SHALL have parameter W_SUPPORT, default 1, enabling 32-bit word ops; it SHALL be ignored when DATA_WIDTH=32.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port enable  input  1  global advance; when low, all state holds.
REQ-006 SHALL have port i_flush  input  1  aborts any operation in progress.
REQ-007 SHALL have port i_start  input  1  request to launch an operation.
REQ-008 SHALL have port i_op  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 SHALL have port i_word  input  1  selects the W variant: 32-bit operation with its result sign-extended.
REQ-010 SHALL have port i_rs1_data  input  DATA_WIDTH  operand A.
REQ-011 SHALL have port i_rs2_data  input  DATA_WIDTH  operand B.
REQ-012 SHALL have port i_rd_addr  input  5  destination register tag.
REQ-013 SHALL have port o_busy  output  1  unit occupied; drives the pipeline stall.
REQ-014 SHALL have port o_valid  output  1  result-valid pulse.
REQ-015 SHALL have port o_result  output  DATA_WIDTH  result data.
REQ-016 SHALL have port o_rd_addr  output  5  tag of the completed operation.

Function
REQ-017 SHALL use an FSM with states IDLE, CALC and DONE.
REQ-018 SHALL leave IDLE for CALC when i_start=1 and enable=1, capturing operands, op, word flag and rd_addr; o_busy SHALL go high the following cycle.
REQ-019 SHALL ignore i_start while not in IDLE.
REQ-020 SHALL perform radix-2 iteration in CALC, one bit per enabled cycle, for N iterations: N=DATA_WIDTH, or N=32 when i_word=1.
REQ-021 SHALL go from CALC to DONE after the Nth iteration.
REQ-022 SHALL, in DONE, drive o_valid=1 for exactly one cycle with the result and tag, then return to IDLE.
REQ-023 SHALL hold o_busy=1 in CALC and DONE, and 0 in IDLE.
REQ-024 SHALL give a latency from start to o_valid of N+2 clocks when enable is held high.
REQ-025 SHALL convert signed operands to magnitudes before iteration and correct the result sign at the end.
REQ-026 SHALL treat MULHSU operand A as signed and operand B as unsigned.
REQ-027 SHALL return the upper DATA_WIDTH bits of the 2*DATA_WIDTH product for MULH, MULHSU and MULHU.
REQ-028 SHALL handle divide by zero without iterating (start to DONE in one cycle, latency 2): quotient all-ones; remainder = dividend.
REQ-029 SHALL handle signed overflow (DIV/REM of most-negative by -1) without iterating: quotient = most-negative; remainder = 0.
REQ-030 SHALL form W-variant results from the low 32 result bits sign-extended to DATA_WIDTH.
REQ-031 SHALL apply REQ-028 and REQ-029 to 32-bit values for W variants.
REQ-032 SHALL treat i_word as 0 when W_SUPPORT=0 or DATA_WIDTH=32.
REQ-033 SHALL, on i_flush=1 in any state, go to IDLE next cycle with no o_valid; flush takes priority over start and completion in the same cycle.
REQ-034 SHALL hold o_result and o_rd_addr at their last values outside DONE.

Reset
REQ-035 SHALL, while reset=1, asynchronously force state=IDLE, o_busy=0, o_valid=0, o_result=0, o_rd_addr=0 and clear internal accumulators.
REQ-036 SHALL treat reset asserted mid-CALC as abandoning the operation with no o_valid; the first start after release SHALL behave as from power-up.

Verification
REQ-037 SHALL be covered: DATA_WIDTH=64, MUL 7 x -3 -> o_valid at cycle 66 after start, result 0xFFFF_FFFF_FFFF_FFEB.
REQ-038 SHALL be covered: MULHU 0xFFFF_FFFF_FFFF_FFFF squared -> result 0xFFFF_FFFF_FFFF_FFFE.
REQ-039 SHALL be covered: DIV 100 / 0 -> o_valid 2 cycles after start, result all-ones; REM 100 / 0 -> 100.
REQ-040 SHALL be covered: DIV 0x8000_0000_0000_0000 / -1 -> result 0x8000_0000_0000_0000; REM of the same -> 0.
REQ-041 SHALL be covered: DIVW with rs1=0xFFFF_FFFF_8000_0000 and rs2=2 -> latency 34, result 0xFFFF_FFFF_C000_0000.
REQ-042 SHALL be covered: i_flush at cycle 10 of CALC, and separately reset mid-CALC -> no o_valid; o_busy=0 next cycle; a new start completes correctly.

Source files
------------

// File: rtl/riscv_ex_muldiv_unit.sv
// rtl/riscv_ex_muldiv_unit.sv - iterative radix-2 RISC-V M-extension multiply/divide unit
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   enable            global advance; all state holds while low (flush still acts)
//   i_flush           abort any operation in progress
//   i_start, i_op     launch request and operation (0 MUL .. 7 REMU)
//   i_word            32-bit W variant, result sign-extended
//   i_rs1_data/rs2    operands A and B
//   i_rd_addr         destination tag, returned on o_rd_addr
//   o_busy            unit occupied (CALC or DONE)
//   o_valid           one-cycle result pulse with o_result / o_rd_addr
module riscv_ex_muldiv_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int W_SUPPORT  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  i_flush,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic                  i_word,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic [4:0]            i_rd_addr,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [4:0]            o_rd_addr
);

    localparam int W       = DATA_WIDTH;
    localparam bit WORD_OK = (W_SUPPORT != 0) && (W == 64);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    function automatic logic [W-1:0] ext32(input logic [31:0] v, input logic s);
        logic signed [31:0] sv;
        sv = v;
        ext32 = s ? W'(sv) : W'(v);
    endfunction

    state_e         state_q, state_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   b_q, b_d;
    logic [2:0]     op_q, op_d;
    logic           word_q, word_d;
    logic           neg_q, neg_d;
    logic           rneg_q, rneg_d;
    logic           special_q, special_d;
    logic [4:0]     rd_q, rd_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   result_q, result_d;
    logic [4:0]     rd_out_q, rd_out_d;

    // Launch decode: operands are sign/zero-extended to W bits first so the
    // W variants share the full-width magnitude and special-case logic.
    logic           word_in, sgn_a, sgn_b, a_neg, b_neg, div0, ovf;
    logic [W-1:0]   a_val, b_val, a_mag, b_mag, min_val;

    always_comb begin
        word_in = i_word & WORD_OK;
        sgn_a   = (i_op inside {3'd0, 3'd1, 3'd2}) | (i_op[2] & ~i_op[0]);
        sgn_b   = (i_op inside {3'd0, 3'd1}) | (i_op[2] & ~i_op[0]);
        a_val   = word_in ? ext32(i_rs1_data[31:0], sgn_a) : i_rs1_data;
        b_val   = word_in ? ext32(i_rs2_data[31:0], sgn_b) : i_rs2_data;
        a_neg   = sgn_a & a_val[W-1];
        b_neg   = sgn_b & b_val[W-1];
        a_mag   = a_neg ? -a_val : a_val;
        b_mag   = b_neg ? -b_val : b_val;
        min_val = word_in ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(W-1){1'b0}}};
        div0    = i_op[2] & (b_val == '0);
        ovf     = i_op[2] & ~i_op[0] & (a_val == min_val) & (b_val == '1);
    end

    // One radix-2 step. {hi,lo} is a 2W shift register: for multiply hi holds
    // the partial product and lo the remaining multiplier bits; for divide hi
    // holds the partial remainder and lo shifts dividend bits out / quotient in.
    logic [W:0] mul_sum, div_sh, div_diff;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh   = {hi_q, lo_q[W-1]};
        div_diff = div_sh - {1'b0, b_q};
    end

    // Final result. After only 32 multiply steps the product sits 32 bits
    // high in {hi,lo}, hence the realignment shift for word ops.
    logic [2*W-1:0] prod, prod_s;
    logic [W-1:0]   mul_hi, mul_res, quo, rem, raw, res;

    always_comb begin
        prod    = word_q ? ({hi_q, lo_q} >> (W - 32)) : {hi_q, lo_q};
        prod_s  = neg_q ? -prod : prod;
        mul_hi  = word_q ? W'(prod_s[63:32]) : prod_s[2*W-1:W];
        mul_res = (op_q == 3'd0) ? prod_s[W-1:0] : mul_hi;
        quo     = neg_q ? -lo_q : lo_q;
        rem     = rneg_q ? -hi_q : hi_q;
        if (special_q) begin
            raw = lo_q;
        end else if (op_q[2]) begin
            raw = op_q[1] ? rem : quo;
        end else begin
            raw = mul_res;
        end
        res = word_q ? ext32(raw[31:0], 1'b1) : raw;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        op_d      = op_q;
        word_d    = word_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        special_d = special_q;
        rd_d      = rd_q;
        valid_d   = valid_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;

        if (enable) begin
            valid_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        op_d      = i_op;
                        word_d    = word_in;
                        rd_d      = i_rd_addr;
                        neg_d     = a_neg ^ b_neg;
                        rneg_d    = a_neg;
                        special_d = div0 | ovf;
                        hi_d      = '0;
                        b_d       = b_mag;
                        cnt_d     = word_in ? 7'd31 : 7'(W - 1);
                        // Special cases park their final value in lo and skip CALC.
                        if (div0) begin
                            lo_d    = i_op[1] ? i_rs1_data : '1;
                            state_d = DONE;
                        end else if (ovf) begin
                            lo_d    = i_op[1] ? '0 : i_rs1_data;
                            state_d = DONE;
                        end else begin
                            // Word divides pre-align the 32-bit dividend to the top of lo.
                            lo_d    = (i_op[2] && word_in) ? (a_mag << (W - 32)) : a_mag;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        if (!div_diff[W]) begin
                            hi_d = div_diff[W-1:0];
                            lo_d = {lo_q[W-2:0], 1'b1};
                        end else begin
                            hi_d = div_sh[W-1:0];
                            lo_d = {lo_q[W-2:0], 1'b0};
                        end
                    end else begin
                        hi_d = mul_sum[W:1];
                        lo_d = {mul_sum[0], lo_q[W-1:1]};
                    end
                    if (cnt_q == 7'd0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
                DONE: begin
                    result_d = res;
                    rd_out_d = rd_q;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (i_flush) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            op_q      <= '0;
            word_q    <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            special_q <= 1'b0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            op_q      <= op_d;
            word_q    <= word_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            special_q <= special_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign o_busy    = (state_q != IDLE);
    assign o_valid   = valid_q;
    assign o_result  = result_q;
    assign o_rd_addr = rd_out_q;

endmodule
